// File: rtl/net_pkg.sv
// Shared definitions for the digit-detector pipeline sequencer: FSM encoding,
// timeout result code, stage-index width and default ping-pong buffer bases.
package net_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [3:0] RESULT_TIMEOUT = 4'hF;
  localparam int         STAGE_IDX_W    = 3;
  localparam int         MEM_A_BASE_DEF = 0;
  localparam int         MEM_B_BASE_DEF = 4096;

endpackage

// File: rtl/net_seq_watchdog.sv
// Per-stage cycle watchdog for net_sequencer, only built when NET_SEQ_WATCHDOG_EN
// is defined. Counts RUN cycles since the last RUN entry and flags the limit.
module net_seq_watchdog
  import net_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1048575
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int              CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_r;

  // expired asserts during the TIMEOUT_CYCLES-th RUN cycle so the FSM aborts on that edge
  assign expired = count_en && (count_r == LIMIT);

  // RUN-cycle counter, saturating at the limit
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (count_en && !expired) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/net_sequencer.sv
// Top-level stage scheduler: one-hot stage enables, ping-pong pixel-memory bases,
// latched class result. Optional watchdog under macro NET_SEQ_WATCHDOG_EN.
module net_sequencer
  import net_pkg::*;
#(
  parameter int NUM_STAGES       = 6,
  parameter int SIZE_address_pix = 13,
  parameter int MEM_A_BASE       = MEM_A_BASE_DEF,
  parameter int MEM_B_BASE       = MEM_B_BASE_DEF,
  parameter int TIMEOUT_CYCLES   = 1048575
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        go,
  output logic                        busy,
  output logic                        done,
  output logic [NUM_STAGES-1:0]       stage_en,
  input  logic [NUM_STAGES-1:0]       stage_stop,
  output logic [SIZE_address_pix-1:0] memstartp,
  output logic [SIZE_address_pix-1:0] memstartzap,
  output logic [STAGE_IDX_W-1:0]      stage_idx,
  input  logic [3:0]                  result_in,
  output logic [3:0]                  RESULT,
  output logic                        timeout_err
);

  localparam logic [SIZE_address_pix-1:0] ADDR_A   = SIZE_address_pix'(MEM_A_BASE);
  localparam logic [SIZE_address_pix-1:0] ADDR_B   = SIZE_address_pix'(MEM_B_BASE);
  localparam logic [STAGE_IDX_W-1:0]      LAST_IDX = STAGE_IDX_W'(NUM_STAGES - 1);

  state_t                      state_r,  state_n;
  logic [STAGE_IDX_W-1:0]      idx_r,    idx_n;
  logic [NUM_STAGES-1:0]       en_r,     en_n;
  logic                        busy_r,   busy_n;
  logic                        done_r,   done_n;
  logic [SIZE_address_pix-1:0] memp_r,   memp_n;
  logic [SIZE_address_pix-1:0] memz_r,   memz_n;
  logic [3:0]                  result_r, result_n;
  logic                        stop_sel_s;

`ifdef NET_SEQ_WATCHDOG_EN
  logic terr_r, terr_n;
  logic wd_expired_s;
  logic wd_clear_s;
  logic wd_count_s;

  assign wd_clear_s = (state_n == ST_RUN) && (state_r != ST_RUN);
  assign wd_count_s = (state_r == ST_RUN);

  net_seq_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (wd_clear_s),
    .count_en (wd_count_s),
    .expired  (wd_expired_s)
  );

  assign timeout_err = terr_r;
`else
  assign timeout_err = 1'b0;
`endif

  assign busy        = busy_r;
  assign done        = done_r;
  assign stage_en    = en_r;
  assign memstartp   = memp_r;
  assign memstartzap = memz_r;
  assign stage_idx   = idx_r;
  assign RESULT      = result_r;

  // Only the active stage's STOP is visible to the FSM
  always_comb begin
    stop_sel_s = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (idx_r == STAGE_IDX_W'(i)) begin
        stop_sel_s = stage_stop[i];
      end else begin
        stop_sel_s = stop_sel_s;
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n  = state_r;
    idx_n    = idx_r;
    en_n     = en_r;
    busy_n   = busy_r;
    done_n   = done_r;
    memp_n   = memp_r;
    memz_n   = memz_r;
    result_n = result_r;
`ifdef NET_SEQ_WATCHDOG_EN
    terr_n   = terr_r;
`endif
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (go) begin
          state_n = ST_RUN;
          idx_n   = '0;
          en_n    = NUM_STAGES'(1);
          busy_n  = 1'b1;
          done_n  = 1'b0;
          memp_n  = ADDR_A;
          memz_n  = ADDR_B;
        end else begin
          state_n = state_r;
        end
      end
      ST_RUN: begin
        if (stop_sel_s) begin
          en_n = '0;
          if (idx_r == LAST_IDX) begin
            state_n  = ST_DONE;
            busy_n   = 1'b0;
            done_n   = 1'b1;
            result_n = result_in;
          end else begin
            state_n = ST_GAP;
          end
        end
`ifdef NET_SEQ_WATCHDOG_EN
        else if (wd_expired_s) begin
          state_n  = ST_DONE;
          en_n     = '0;
          busy_n   = 1'b0;
          done_n   = 1'b1;
          result_n = RESULT_TIMEOUT;
          terr_n   = 1'b1;
        end
`endif
        else begin
          state_n = ST_RUN;
        end
      end
      ST_GAP: begin
        // One all-low cycle lets the finished stage clear its counter and STOP
        state_n = ST_RUN;
        idx_n   = idx_r + STAGE_IDX_W'(1);
        en_n    = NUM_STAGES'(1) << idx_n;
        memp_n  = idx_n[0] ? ADDR_B : ADDR_A;
        memz_n  = idx_n[0] ? ADDR_A : ADDR_B;
      end
      default: begin
        state_n = ST_IDLE;
        en_n    = '0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      idx_r    <= '0;
      en_r     <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      memp_r   <= '0;
      memz_r   <= '0;
      result_r <= 4'd0;
`ifdef NET_SEQ_WATCHDOG_EN
      terr_r   <= 1'b0;
`endif
    end else begin
      state_r  <= state_n;
      idx_r    <= idx_n;
      en_r     <= en_n;
      busy_r   <= busy_n;
      done_r   <= done_n;
      memp_r   <= memp_n;
      memz_r   <= memz_n;
      result_r <= result_n;
`ifdef NET_SEQ_WATCHDOG_EN
      terr_r   <= terr_n;
`endif
    end
  end

endmodule

// File: tb/tb_net_sequencer.sv
// Scoreboard bench for net_sequencer: stimulus pushes expected output changes
// (with cycle stamps) and probes; a negedge monitor pops and compares.
module tb_net_sequencer;

  localparam int NS = 6;

  logic        clk = 1'b0;
  logic        rst, go;
  logic        busy, done, timeout_err;
  logic [5:0]  stage_en, stage_stop;
  logic [12:0] memstartp, memstartzap;
  logic [2:0]  stage_idx;
  logic [3:0]  result_in, RESULT;

  always #5 clk = ~clk;

  net_sequencer #(
    .NUM_STAGES       (NS),
    .SIZE_address_pix (13),
    .MEM_A_BASE       (0),
    .MEM_B_BASE       (4096),
    .TIMEOUT_CYCLES   (50)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .go          (go),
    .busy        (busy),
    .done        (done),
    .stage_en    (stage_en),
    .stage_stop  (stage_stop),
    .memstartp   (memstartp),
    .memstartzap (memstartzap),
    .stage_idx   (stage_idx),
    .result_in   (result_in),
    .RESULT      (RESULT),
    .timeout_err (timeout_err)
  );

  // Stub stages: STOP rises 10 cycles after enable, held until enable drops
  logic [7:0] scnt [NS];
  logic [5:0] sstop, stall, force_stop;
  assign stage_stop = (sstop & ~stall) | force_stop;

  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (!stage_en[i]) begin
        scnt[i]  <= 8'd0;
        sstop[i] <= 1'b0;
      end else begin
        if (scnt[i] != 8'd255) scnt[i] <= scnt[i] + 8'd1;
        if (scnt[i] == 8'd9) sstop[i] <= 1'b1;
      end
    end
  end

  typedef struct packed {
    logic [5:0]  en;
    logic [2:0]  idx;
    logic [12:0] p;
    logic [12:0] z;
    logic        busy;
    logic        done;
    logic [3:0]  res;
    logic        terr;
  } obs_t;
  typedef struct packed { logic [31:0] cyc; obs_t o; } ev_t;
  typedef struct packed { logic kind; obs_t o; } probe_t;

  ev_t    evq[$];
  probe_t prq[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  bit     mon_on = 1'b0;
  obs_t   prev, cur;
  ev_t    ev;
  probe_t pr;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic obs_t mk(input logic [5:0] en, input logic [2:0] idx,
                              input logic [12:0] p, input logic [12:0] z,
                              input logic b, input logic d,
                              input logic [3:0] res, input logic terr);
    obs_t o;
    o.en = en; o.idx = idx; o.p = p; o.z = z;
    o.busy = b; o.done = d; o.res = res; o.terr = terr;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("en=%b idx=%0d p=%0d z=%0d busy=%b done=%b res=%0d terr=%b",
                     o.en, o.idx, o.p, o.z, o.busy, o.done, o.res, o.terr);
  endfunction

  // Monitor: handles probes, then compares each observed output change
  always @(negedge clk) begin
    cur = mk(stage_en, stage_idx, memstartp, memstartzap, busy, done, RESULT, timeout_err);
    while (prq.size() > 0) begin
      pr = prq.pop_front();
      checks++;
      if (pr.kind) begin
        errors++;
      end else if (cur !== pr.o) begin
        errors++;
        $display("FAIL probe at cyc %0d: got %s want %s", cyc, fmt(cur), fmt(pr.o));
      end
    end
    if (mon_on && cur !== prev) begin
      checks++;
      if (evq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change at cyc %0d: got %s want no change", cyc, fmt(cur));
      end else begin
        ev = evq.pop_front();
        if (ev.cyc != 32'(cyc) || ev.o !== cur) begin
          errors++;
          $display("FAIL event: got cyc=%0d %s want cyc=%0d %s", cyc, fmt(cur), ev.cyc, fmt(ev.o));
        end
      end
    end
    prev = cur;
  end

  function automatic ev_t mkev(input int c, input obs_t o);
    ev_t e;
    e.cyc = 32'(c);
    e.o   = o;
    return e;
  endfunction

  // Expected change list for one run started by go driven at cycle c0.
  // d1 = stage-1 enable length; cut = last stage reached before an external
  // reset; wd = stage that never stops (watchdog build).
  task automatic push_run(input int c0, input int d1, input logic [3:0] res,
                          input logic [3:0] old, input int cut, input int wd);
    int t, d;
    logic [12:0] p, z;
    t = c0 + 1;
    for (int k = 0; k < NS; k++) begin
      p = (k % 2 == 1) ? 13'd4096 : 13'd0;
      z = (k % 2 == 1) ? 13'd0 : 13'd4096;
      evq.push_back(mkev(t, mk(6'(1 << k), 3'(k), p, z, 1'b1, 1'b0, old, 1'b0)));
      if (k == cut) return;
      if (k == wd) begin
        evq.push_back(mkev(t + 50, mk(6'd0, 3'(k), p, z, 1'b0, 1'b1, 4'hF, 1'b1)));
        return;
      end
      d = (k == 1) ? d1 : 11;
      if (k < NS - 1) begin
        evq.push_back(mkev(t + d, mk(6'd0, 3'(k), p, z, 1'b1, 1'b0, old, 1'b0)));
        t = t + d + 1;
      end else begin
        evq.push_back(mkev(t + d, mk(6'd0, 3'(k), p, z, 1'b0, 1'b1, res, 1'b0)));
      end
    end
  endtask

  task automatic go_pulse();
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic drain(input int limit);
    int i;
    i = 0;
    while (evq.size() != 0 && i < limit) begin
      @(negedge clk);
      i++;
    end
    if (evq.size() != 0) begin
      $display("FAIL drain_timeout: got %0d pending events want 0", evq.size());
      prq.push_back('{1'b1, '0});
      evq.delete();
    end
  endtask

  int c0;

  initial begin
    rst = 1'b1; go = 1'b0; result_in = 4'd0;
    stall = 6'd0; force_stop = 6'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    prq.push_back('{1'b0, mk(6'd0, 3'd0, 13'd0, 13'd0, 1'b0, 1'b0, 4'd0, 1'b0)});
    @(negedge clk);
    mon_on = 1'b1;

    // Full run with result 7; go held through RUN and GAP of stage 2 is ignored
    result_in = 4'd7;
    c0 = cyc;
    push_run(c0, 11, 4'd7, 4'd0, -1, -1);
    go_pulse();
    wait_until(c0 + 30);
    go = 1'b1;
    wait_until(c0 + 37);
    go = 1'b0;
    drain(120);

    // Restart from DONE; foreign stop[4] during a stalled stage 1 is ignored
    result_in = 4'd9;
    c0 = cyc;
    stall = 6'b000010;
    push_run(c0, 29, 4'd9, 4'd7, -1, -1);
    go_pulse();
    wait_until(c0 + 15);
    force_stop = 6'b010000;
    wait_until(c0 + 41);
    stall = 6'd0;
    force_stop = 6'd0;
    drain(150);
    result_in = 4'd3;
    repeat (10) @(negedge clk);
    prq.push_back('{1'b0, mk(6'd0, 3'd5, 13'd4096, 13'd0, 1'b0, 1'b1, 4'd9, 1'b0)});

    // Reset during stage 3 RUN clears everything on the next edge
    result_in = 4'd4;
    c0 = cyc;
    push_run(c0, 11, 4'd4, 4'd9, 3, -1);
    go_pulse();
    wait_until(c0 + 40);
    rst = 1'b1;
    evq.push_back(mkev(c0 + 41, mk(6'd0, 3'd0, 13'd0, 13'd0, 1'b0, 1'b0, 4'd0, 1'b0)));
    @(negedge clk);
    rst = 1'b0;
    drain(20);
    repeat (3) @(negedge clk);

    // Fresh go after reset restarts at stage 0
    result_in = 4'd5;
    c0 = cyc;
    push_run(c0, 11, 4'd5, 4'd0, -1, -1);
    go_pulse();
    drain(120);

`ifdef NET_SEQ_WATCHDOG_EN
    // Stage 2 never stops: abort after 50 RUN cycles
    stall = 6'b000100;
    c0 = cyc;
    push_run(c0, 11, 4'd0, 4'd5, -1, 2);
    go_pulse();
    drain(150);
    stall = 6'd0;
`endif

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
